// File: rtl/uart_tester_pkg.sv
// Shared definitions for the UART tester controller: register offsets, FSM states and
// byte-lane helpers for the 32-bit native bus.
package uart_tester_pkg;

  localparam logic [7:0] OFF_SOFTRESET = 8'd0;
  localparam logic [7:0] OFF_DIV       = 8'd2;
  localparam logic [7:0] OFF_TXDATA    = 8'd4;
  localparam logic [7:0] OFF_TXEN      = 8'd5;
  localparam logic [7:0] OFF_TXREADY   = 8'd6;
  localparam logic [7:0] OFF_RXDATA    = 8'd8;
  localparam logic [7:0] OFF_RXEN      = 8'd9;
  localparam logic [7:0] OFF_RXREADY   = 8'd10;

  typedef enum logic [3:0] {
    INIT_SR1,
    INIT_SR0,
    INIT_DIV,
    INIT_TXEN,
    INIT_RXEN,
    IDLE,
    TX_POLL,
    TX_WR,
    RX_POLL,
    RX_RD
  } state_t;

  // Byte enables for a byte (half=0) or 16-bit (half=1) write starting at the given lane.
  function automatic logic [3:0] lane_strb(input logic [1:0] lane, input logic half);
    return half ? (4'b0011 << lane) : (4'b0001 << lane);
  endfunction

  // Bit shift that moves a value into (or out of) the given byte lane.
  function automatic logic [4:0] lane_shift(input logic [1:0] lane);
    return {lane, 3'b000};
  endfunction

endpackage

// File: rtl/uart_tester_ctrl_if.sv
// Native request/response bus between the tester controller (master) and the UART core (slave).
interface uart_tester_ctrl_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              uart_valid;
  logic [ADDR_W-1:0] uart_addr;
  logic [DATA_W-1:0] uart_wdata;
  logic [3:0]        uart_wstrb;
  logic [DATA_W-1:0] uart_rdata;
  logic              uart_ready;

  modport master (
    output uart_valid, uart_addr, uart_wdata, uart_wstrb,
    input  uart_rdata, uart_ready
  );

  modport slave (
    input  uart_valid, uart_addr, uart_wdata, uart_wstrb,
    output uart_rdata, uart_ready
  );
endinterface

// File: rtl/uart_tester_ctrl.sv
// Initialises a register-mapped UART core, then services a tx byte stream and an rx byte
// stream by polling it. Optional request timeout under macro UART_TESTER_TIMEOUT_EN.
module uart_tester_ctrl
  import uart_tester_pkg::*;
#(
  parameter int          DATA_W  = 32,
  parameter int          ADDR_W  = 5,
  parameter logic [15:0] DIV     = 16'd100,
  parameter int          TIMEOUT = 1024
) (
  input  logic                 clk,
  input  logic                 rst,
  uart_tester_ctrl_if.master   uart,
  input  logic                 tx_valid,
  input  logic [7:0]           tx_data,
  output logic                 tx_ready,
  output logic                 rx_valid,
  output logic [7:0]           rx_data,
  input  logic                 rx_ready,
  output logic                 init_done,
`ifdef UART_TESTER_TIMEOUT_EN
  output logic                 error,
`endif
  output state_t               state_dbg
);

  // Handshakes: a stream byte moves on any posedge where valid & ready are both high; valid
  // never waits on ready. A bus request holds all fields until the edge that samples
  // uart_ready=1, then valid drops for at least one cycle before the next request.

  state_t            state, state_n;
  logic              req_valid, req_valid_n;
  logic [ADDR_W-1:0] req_addr, req_addr_n;
  logic [DATA_W-1:0] req_wdata, req_wdata_n;
  logic [3:0]        req_wstrb, req_wstrb_n;

  logic       tx_full, rx_full, done;
  logic [7:0] tx_byte, rx_byte;
  logic       tx_clr, rx_load, done_set, timeout;

  logic [7:0]  cmd_off;
  logic [15:0] cmd_val;
  logic        cmd_wr, cmd_half;
  logic [1:0]  cmd_lane;
  logic [7:0]  rd_byte;

  always_comb begin
    cmd_off  = OFF_SOFTRESET;
    cmd_val  = 16'd0;
    cmd_wr   = 1'b0;
    cmd_half = 1'b0;
    case (state)
      INIT_SR1:  begin cmd_wr = 1'b1; cmd_val = 16'd1; end
      INIT_SR0:  begin cmd_wr = 1'b1; end
      INIT_DIV:  begin cmd_off = OFF_DIV; cmd_val = DIV; cmd_wr = 1'b1; cmd_half = 1'b1; end
      INIT_TXEN: begin cmd_off = OFF_TXEN; cmd_val = 16'd1; cmd_wr = 1'b1; end
      INIT_RXEN: begin cmd_off = OFF_RXEN; cmd_val = 16'd1; cmd_wr = 1'b1; end
      TX_POLL:   cmd_off = OFF_TXREADY;
      TX_WR:     begin cmd_off = OFF_TXDATA; cmd_val = {8'h00, tx_byte}; cmd_wr = 1'b1; end
      RX_POLL:   cmd_off = OFF_RXREADY;
      RX_RD:     cmd_off = OFF_RXDATA;
      default:   ;
    endcase
  end

  assign cmd_lane = cmd_off[1:0];
  assign rd_byte  = 8'(uart.uart_rdata >> lane_shift(req_addr[1:0]));

  always_comb begin
    state_n     = state;
    req_valid_n = req_valid;
    req_addr_n  = req_addr;
    req_wdata_n = req_wdata;
    req_wstrb_n = req_wstrb;
    tx_clr      = 1'b0;
    rx_load     = 1'b0;
    done_set    = 1'b0;

    if (state == IDLE) begin
      if (tx_full)       state_n = TX_POLL;
      else if (!rx_full) state_n = RX_POLL;
    end else if (!req_valid) begin
      req_valid_n = 1'b1;
      req_addr_n  = ADDR_W'(cmd_off);
      req_wdata_n = cmd_wr ? (DATA_W'(cmd_val) << lane_shift(cmd_lane)) : '0;
      req_wstrb_n = cmd_wr ? lane_strb(cmd_lane, cmd_half) : 4'b0000;
    end else if (uart.uart_ready) begin
      req_valid_n = 1'b0;
      req_addr_n  = '0;
      req_wdata_n = '0;
      req_wstrb_n = '0;
      case (state)
        INIT_SR1:  state_n = INIT_SR0;
        INIT_SR0:  state_n = INIT_DIV;
        INIT_DIV:  state_n = INIT_TXEN;
        INIT_TXEN: state_n = INIT_RXEN;
        INIT_RXEN: begin state_n = IDLE; done_set = 1'b1; end
        TX_POLL: begin
          if (rd_byte[0])    state_n = TX_WR;
          else if (!rx_full) state_n = RX_POLL;
          else               state_n = IDLE;
        end
        // Offer the rx side a turn after every tx byte so neither direction starves.
        TX_WR: begin
          tx_clr  = 1'b1;
          state_n = rx_full ? IDLE : RX_POLL;
        end
        RX_POLL: state_n = rd_byte[0] ? RX_RD : IDLE;
        RX_RD:   begin rx_load = 1'b1; state_n = IDLE; end
        default: state_n = INIT_SR1;
      endcase
    end

    if (timeout) begin
      req_valid_n = 1'b0;
      req_addr_n  = '0;
      req_wdata_n = '0;
      req_wstrb_n = '0;
      state_n     = INIT_SR1;
      tx_clr      = 1'b0;
      rx_load     = 1'b0;
      done_set    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= INIT_SR1;
      req_valid <= 1'b0;
      req_addr  <= '0;
      req_wdata <= '0;
      req_wstrb <= '0;
    end else begin
      state     <= state_n;
      req_valid <= req_valid_n;
      req_addr  <= req_addr_n;
      req_wdata <= req_wdata_n;
      req_wstrb <= req_wstrb_n;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || timeout) begin
      tx_full <= 1'b0;
      tx_byte <= 8'h00;
      rx_full <= 1'b0;
      rx_byte <= 8'h00;
      done    <= 1'b0;
    end else begin
      if (tx_valid && tx_ready) begin
        tx_full <= 1'b1;
        tx_byte <= tx_data;
      end else if (tx_clr) begin
        tx_full <= 1'b0;
      end
      // RXREADY is only polled with the holding register empty, so load and drain never collide.
      if (rx_load) begin
        rx_full <= 1'b1;
        rx_byte <= rd_byte;
      end else if (rx_valid && rx_ready) begin
        rx_full <= 1'b0;
      end
      if (done_set) done <= 1'b1;
    end
  end

`ifdef UART_TESTER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] wait_cnt;

  assign timeout = req_valid && !uart.uart_ready && (wait_cnt == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst || !req_valid || uart.uart_ready || timeout) wait_cnt <= '0;
    else                                                   wait_cnt <= wait_cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst)          error <= 1'b0;
    else if (timeout) error <= 1'b1;
  end
`else
  logic unused_timeout;
  assign timeout        = 1'b0;
  assign unused_timeout = (TIMEOUT == 0);
`endif

  assign uart.uart_valid = req_valid;
  assign uart.uart_addr  = req_addr;
  assign uart.uart_wdata = req_wdata;
  assign uart.uart_wstrb = req_wstrb;

  assign tx_ready  = done && !tx_full;
  assign rx_valid  = rx_full;
  assign rx_data   = rx_byte;
  assign init_done = done;
  assign state_dbg = state;

endmodule
